// File: rtl/bit_filler.sv
// bit_filler: count-to-pattern generator.
// Accepts a count N and builds a W-bit word with min(N, W) ones, shifting
// one bit in per cycle under a three-state controller (IDLE -> FILL -> DONE).
// Optional build macro: BIT_FILLER_MSB_FIRST_EN
//   undefined: ones enter at bit 0 and pack at the LSB end (N=3 -> 0000_0111).
//   defined:   ones enter at bit W-1 and pack at the MSB end (N=3 -> 1110_0000).
module bit_filler #(
    parameter int W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(W+1)-1:0]     count,
    output logic [W-1:0]               pattern,
    output logic                       busy,
    output logic                       done,
    output logic                       ovf
);

    localparam int CW = $clog2(W+1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [W-1:0]  pattern_reg, pattern_next;
    logic [CW-1:0] remaining_reg, remaining_next;
    logic          ovf_reg, ovf_next;

    logic [W-1:0]  shifted;
    logic          count_over;

    // A request larger than the register width is clamped and flagged.
    assign count_over = (int'(count) > W);

    // One-bit shift of the pattern with a 1 entering at the fill end.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_shift
`ifdef BIT_FILLER_MSB_FIRST_EN
            if (gi == W - 1) begin : g_end
                assign shifted[gi] = 1'b1;
            end else begin : g_mid
                assign shifted[gi] = pattern_reg[gi+1];
            end
`else
            if (gi == 0) begin : g_end
                assign shifted[gi] = 1'b1;
            end else begin : g_mid
                assign shifted[gi] = pattern_reg[gi-1];
            end
`endif
        end
    endgenerate

    // Controller and datapath next-state logic.
    always_comb begin
        state_next     = state_reg;
        pattern_next   = pattern_reg;
        remaining_next = remaining_reg;
        ovf_next       = ovf_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    pattern_next   = '0;
                    remaining_next = count_over ? CW'(W) : count;
                    ovf_next       = count_over;
                    state_next     = ST_FILL;
                end
            end
            ST_FILL: begin
                // Decrement only while nonzero, so remaining never wraps.
                if (remaining_reg != '0) begin
                    pattern_next   = shifted;
                    remaining_next = remaining_reg - CW'(1);
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // A held start must drop before another run can begin.
                if (!start) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            pattern_reg   <= '0;
            remaining_reg <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pattern_reg   <= pattern_next;
            remaining_reg <= remaining_next;
            ovf_reg       <= ovf_next;
        end
    end

    assign pattern = pattern_reg;
    assign busy    = (state_reg == ST_FILL);
    assign done    = (state_reg == ST_DONE);
    assign ovf     = ovf_reg;

endmodule
